// File: rtl/uart_fifo_core.sv
// uart_fifo_core
// Byte-level UART engine. The host pushes bytes into a TX FIFO, and they drain
// automatically onto tx as 8N1-style frames. Frames received on rx are pushed
// into an RX FIFO, and the host pops them from there.
//
// Parameters:
//   CLK_FREQ, BIT_RATE  clock and bit rate; CPB = CLK_FREQ/BIT_RATE clocks per bit (>= 4)
//   PAYLOAD_BITS        data bits per frame and FIFO width (>= 2)
//   BUFFER_SIZE         entries per FIFO (power of two, >= 2)
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   rx / tx             serial in (asynchronous to clk) / serial out, both idle high
//   tx_write, tx_data   push a byte into the TX FIFO
//   tx_full, tx_empty   TX FIFO status
//   rx_read             pop the head of the RX FIFO
//   rx_data             RX FIFO head, first-word-fall-through, valid while !rx_empty
//   rx_full, rx_empty   RX FIFO status
//   rx_break            one-cycle pulse when a break frame is received (data all 0, stop 0)

// Synchronous FIFO with a registered count and wrapping pointers.
// The head is read combinationally from the storage array.
module uart_fifo_core_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Entries are only read after they are
  // written, and leaving it out of reset lets it map onto plain RAM or flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module uart_fifo_core #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUFFER_SIZE  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  output logic                    tx,
  input  logic                    tx_write,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    tx_full,
  output logic                    tx_empty,
  input  logic                    rx_read,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_full,
  output logic                    rx_empty,
  output logic                    rx_break
);
  localparam int CPB  = CLK_FREQ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int IW   = $clog2(PAYLOAD_BITS);
  localparam int PB   = PAYLOAD_BITS;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // ---------------------------------------------------------------- TX path
  uart_state_t   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [IW-1:0] tx_idx, tx_idx_n;
  logic [PB-1:0] tx_shift, tx_shift_n;
  logic          tx_line, tx_line_n;
  logic          tx_pop;
  logic [PB-1:0] txf_head;

  uart_fifo_core_fifo #(.WIDTH(PB), .DEPTH(BUFFER_SIZE)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_write),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (txf_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // The next line level is computed together with the state, so tx comes
  // straight from a register and changes on the same edge the state changes.
  // NOTE: every signal written here gets a default first. A path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_line_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = txf_head;
          tx_cnt_n   = '0;
          tx_line_n  = 1'b0;
          tx_state_n = S_START;
        end
      end
      S_START: begin
        if (tx_cnt == CW'(CPB - 1)) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_line_n  = tx_shift[0];
          tx_state_n = S_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt == CW'(CPB - 1)) begin
          tx_cnt_n = '0;
          if (tx_idx == IW'(PB - 1)) begin
            tx_line_n  = 1'b1;
            tx_state_n = S_STOP;
          end else begin
            tx_idx_n   = tx_idx + IW'(1);
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt == CW'(CPB - 1)) begin
          tx_cnt_n   = '0;
          tx_state_n = S_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  assign tx = tx_line;

  // ---------------------------------------------------------------- RX path
  uart_state_t   rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [IW-1:0] rx_idx, rx_idx_n;
  logic [PB-1:0] rx_shift, rx_shift_n;
  logic [1:0]    rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic          rx_push, rx_push_n;
  logic          rx_break_n;

  // Two-flop synchronizer. rx_prev holds the previous synchronized level, so a
  // new frame starts only on a high-to-low transition, never on a line that
  // stays low after a break.
  assign rx_sync = rx_meta[1];

  uart_fifo_core_fifo #(.WIDTH(PB), .DEPTH(BUFFER_SIZE)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_read),
    .head      (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_push_n  = 1'b0;
    rx_break_n = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_cnt_n   = '0;
          rx_state_n = S_START;
        end
      end
      S_START: begin
        // Re-check at mid start bit: a line that is high again was a glitch.
        if (rx_cnt == CW'(HALF - 1)) begin
          rx_cnt_n = '0;
          if (rx_sync) begin
            rx_state_n = S_IDLE;
          end else begin
            rx_idx_n   = '0;
            rx_state_n = S_DATA;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt == CW'(CPB - 1)) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[PB-1:1]};
          if (rx_idx == IW'(PB - 1)) rx_state_n = S_STOP;
          else                       rx_idx_n   = rx_idx + IW'(1);
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt == CW'(CPB - 1)) begin
          rx_cnt_n   = '0;
          rx_state_n = S_IDLE;
          if (rx_sync)              rx_push_n  = 1'b1;
          else if (rx_shift == '0)  rx_break_n = 1'b1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
    endcase
  end

  // The completed byte stays in rx_shift while the engine idles, so the push
  // one cycle after the stop sample still carries it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      rx_meta  <= {rx_meta[0], rx};
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_push  <= rx_push_n;
      rx_break <= rx_break_n;
    end
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core
// Directed bench for uart_fifo_core with CPB=10, 8 data bits and 4-deep FIFOs.
// The reference model decodes the serial lines frame by frame and keeps the
// expected RX FIFO contents and pending TX frames in queues. One compare
// process checks the RX outputs on every cycle. A serial monitor checks each
// transmitted frame against the queue of accepted bytes.
module tb_uart_fifo_core;
  localparam int CLK_FREQ = 1000000;
  localparam int BIT_RATE = 100000;
  localparam int CPB      = CLK_FREQ / BIT_RATE;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       tx;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_break;

  logic       loop_en;
  logic       rx_drv;
  assign rx = loop_en ? tx : rx_drv;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int         exp_break_pending = 0;
  int         break_seen = 0;
  bit         tx_mon_ignore = 1'b0;

  uart_fifo_core #(
    .CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .BUFFER_SIZE(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .tx       (tx),
    .tx_write (tx_write),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .rx_read  (rx_read),
    .rx_data  (rx_data),
    .rx_full  (rx_full),
    .rx_empty (rx_empty),
    .rx_break (rx_break)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Host-side stimulus. Each call spans exactly one rising edge.
  task automatic push_tx(input logic [7:0] b, input bit accept);
    tx_write = 1'b1;
    tx_data  = b;
    if (accept && !tx_mon_ignore) exp_tx.push_back(b);
    @(posedge clk);
    #1 tx_write = 1'b0;
  endtask

  task automatic pop_rx();
    rx_read = 1'b1;
    @(posedge clk);
    if (exp_rx.size() > 0) void'(exp_rx.pop_front());
    #1 rx_read = 1'b0;
  endtask

  // The serial line is driven just after a rising edge, so neither the DUT
  // nor the negedge model races the change.
  task automatic rx_level(input logic v, input int clocks);
    @(posedge clk);
    #2 rx_drv = v;
    repeat (clocks - 1) @(posedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) rx_level(b[i], CPB);
    rx_level(1'b1, CPB + 2);
  endtask

  task automatic wait_tx_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference receiver for the rx line. A falling edge starts a frame once the
  // line has been seen high. The start bit is re-checked at mid-bit, and data
  // and stop are sampled at bit centres.
  initial begin : rx_model
    bit         armed;
    logic [7:0] b;
    logic       stop_bit;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        armed = 1'b0;
      end else if (rx === 1'b1) begin
        armed = 1'b1;
      end else if (armed) begin
        repeat (CPB / 2) @(negedge clk);
        if (rx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = rx;
          end
          repeat (CPB) @(negedge clk);
          stop_bit = rx;
          if (stop_bit) begin
            if (exp_rx.size() < DEPTH) exp_rx.push_back(b);
          end else if (b == 8'h00) begin
            exp_break_pending++;
          end
          armed = 1'b0;
        end
      end
    end
  end

  // Serial monitor for the tx line. It checks start and stop levels and the
  // decoded byte against the oldest accepted byte.
  initial begin : tx_monitor
    logic [7:0] b;
    logic       start_bit;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        start_bit = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        if (!tx_mon_ignore) begin
          check("tx_start_bit", start_bit, 1'b0);
          check("tx_stop_bit", stop_bit, 1'b1);
          if (exp_tx.size() == 0) fail_now("tx_frame", $sformatf("unexpected byte 0x%0h", b));
          else                    check("tx_frame", b, exp_tx.pop_front());
        end
      end
    end
  end

  // Per-cycle comparison of the RX-side outputs against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!rx_empty) begin
          if (exp_rx.size() == 0) fail_now("rx_head", $sformatf("DUT holds 0x%0h, model empty", rx_data));
          else                    check("rx_head", rx_data, exp_rx[0]);
        end
        if (rx_full) check("rx_full_depth", exp_rx.size(), DEPTH);
        if (rx_break) begin
          break_seen++;
          check("rx_break_expected", (exp_break_pending > 0), 1'b1);
          if (exp_break_pending > 0) exp_break_pending--;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit         ok;
    bit [9:0]   pat;
    int         brk0;
    reset    = 1'b1;
    tx_write = 1'b0;
    tx_data  = '0;
    rx_read  = 1'b0;
    rx_drv   = 1'b1;
    loop_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset_tx", tx, 1'b1);
    check("reset_tx_empty", tx_empty, 1'b1);
    check("reset_tx_full", tx_full, 1'b0);
    check("reset_rx_empty", rx_empty, 1'b1);
    check("reset_rx_full", rx_full, 1'b0);
    check("reset_rx_break", rx_break, 1'b0);

    // Loopback of 0xA5: the tx waveform is pinned bit by bit at bit centres
    loop_en = 1'b1;
    repeat (3) @(negedge clk);
    push_tx(8'hA5, 1'b1);
    wait_tx_low(ok);
    check("a5_start_seen", ok, 1'b1);
    pat = 10'b1101001010;
    repeat (CPB / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("a5_bit%0d", k), tx, pat[k]);
      if (k < 9) repeat (CPB) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("a5_rx_empty", rx_empty, 1'b0);
    check("a5_rx_data", rx_data, 8'hA5);
    pop_rx();
    @(negedge clk);
    check("a5_rx_empty_after_pop", rx_empty, 1'b1);
    loop_en = 1'b0;

    // TX FIFO fill: a lead byte occupies the engine, then four pushes fill the
    // FIFO and a fifth push is dropped
    repeat (5) @(negedge clk);
    push_tx(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    push_tx(8'h01, 1'b1);
    push_tx(8'h02, 1'b1);
    push_tx(8'h03, 1'b1);
    @(negedge clk);
    check("fill3_tx_full", tx_full, 1'b0);
    push_tx(8'h04, 1'b1);
    @(negedge clk);
    check("fill4_tx_full", tx_full, 1'b1);
    check("fill4_tx_empty", tx_empty, 1'b0);
    push_tx(8'h05, 1'b0);
    @(negedge clk);
    check("push_when_full_tx_full", tx_full, 1'b1);
    for (int i = 0; i < 1500 && exp_tx.size() != 0; i++) @(negedge clk);
    check("tx_frames_drained", exp_tx.size(), 0);
    repeat (10) @(negedge clk);
    check("drain_tx_empty", tx_empty, 1'b1);
    check("drain_tx_idle", tx, 1'b1);

    // RX overflow: six frames with no reads, only the first four are kept
    for (int i = 0; i < 6; i++) send_rx(8'h10 + 8'(i));
    repeat (10) @(negedge clk);
    check("ovf_rx_full", rx_full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("ovf_pop%0d", i), rx_data, 8'h10 + 8'(i));
      pop_rx();
    end
    @(negedge clk);
    check("ovf_rx_empty", rx_empty, 1'b1);
    check("ovf_rx_full_clear", rx_full, 1'b0);

    // Break: line held low for ten bit times
    brk0 = break_seen;
    rx_level(1'b0, 10 * CPB);
    rx_level(1'b1, 30);
    @(negedge clk);
    check("break_pulses", break_seen - brk0, 1);
    check("break_rx_empty", rx_empty, 1'b1);
    check("break_model_consumed", exp_break_pending, 0);

    // Glitch: a 3-clock low pulse is rejected and the receiver stays usable
    brk0 = break_seen;
    rx_level(1'b0, 3);
    rx_level(1'b1, 30);
    @(negedge clk);
    check("glitch_rx_empty", rx_empty, 1'b1);
    check("glitch_no_break", break_seen - brk0, 0);
    send_rx(8'h3C);
    repeat (5) @(negedge clk);
    check("after_glitch_rx_data", rx_data, 8'h3C);
    check("after_glitch_rx_empty", rx_empty, 1'b0);

    // Reset in the middle of transmitting 0xFF, with bytes still queued
    // in both FIFOs
    tx_mon_ignore = 1'b1;
    push_tx(8'hFF, 1'b1);
    push_tx(8'h11, 1'b1);
    wait_tx_low(ok);
    check("ff_start_seen", ok, 1'b1);
    repeat (30) @(negedge clk);
    check("pre_reset_tx_empty", tx_empty, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_tx", tx, 1'b1);
    check("midreset_tx_empty", tx_empty, 1'b1);
    check("midreset_rx_empty", rx_empty, 1'b1);
    check("midreset_tx_full", tx_full, 1'b0);
    exp_rx.delete();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_tx_idle", tx, 1'b1);
    check("post_reset_rx_empty", rx_empty, 1'b1);
    check("post_reset_no_break_pending", exp_break_pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
